// File: rtl/acumulador_pkg.sv
// Shared types and constants for the RAM-summing Avalon-MM master.
package acumulador_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WBACK, DONE} state_t;

    localparam logic [2:0] CSR_CTRL      = 3'd0;
    localparam logic [2:0] CSR_STATUS    = 3'd1;
    localparam logic [2:0] CSR_BASE      = 3'd2;
    localparam logic [2:0] CSR_COUNT     = 3'd3;
    localparam logic [2:0] CSR_RESULT_LO = 3'd4;
    localparam logic [2:0] CSR_RESULT_HI = 3'd5;
    localparam logic [2:0] CSR_DEST      = 3'd6;

    localparam int MEM_AW    = 14;
    localparam int MAX_COUNT = 16384;

    function automatic logic [63:0] sext(input logic [31:0] d);
        return {{32{d[31]}}, d};
    endfunction

endpackage

// File: rtl/acumulador_csr.sv
// CSR slave: control/status flags, BASE/COUNT/DEST registers, registered read mux, irq.
// DEST only exists when ACUM_WRITEBACK_EN is defined.
module acumulador_csr #(
    parameter int ACC_W  = 40,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    input  logic              busy,
    input  logic              set_done,
    input  logic              set_ovf,
    input  logic              clr_ovf,
    input  logic [ACC_W-1:0]  acc,
    output logic              start_req,
    output logic [MEM_AW-1:0] base,
`ifdef ACUM_WRITEBACK_EN
    output logic [MEM_AW-1:0] dest,
`endif
    output logic [14:0]       count
);
    import acumulador_pkg::*;

    logic        irq_en, done, ovf;
    logic [31:0] rd_mux;
    logic [63:0] acc_x;
    logic        wr_ctrl, wr_status, wr_base, wr_count;

    assign wr_ctrl   = csr_write && csr_address == CSR_CTRL;
    assign wr_status = csr_write && csr_address == CSR_STATUS;
    assign wr_base   = csr_write && csr_address == CSR_BASE  && !busy;
    assign wr_count  = csr_write && csr_address == CSR_COUNT && !busy;

    assign start_req = wr_ctrl && csr_writedata[0];
    assign irq       = done && irq_en;
    assign acc_x     = 64'($signed(acc));

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL:      rd_mux = {30'd0, irq_en, 1'b0};
            CSR_STATUS:    rd_mux = {29'd0, ovf, done, busy};
            CSR_BASE:      rd_mux = 32'(base);
            CSR_COUNT:     rd_mux = 32'(count);
            CSR_RESULT_LO: rd_mux = acc_x[31:0];
            CSR_RESULT_HI: rd_mux = acc_x[63:32];
`ifdef ACUM_WRITEBACK_EN
            CSR_DEST:      rd_mux = 32'(dest);
`endif
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en       <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            base         <= '0;
            count        <= '0;
`ifdef ACUM_WRITEBACK_EN
            dest         <= '0;
`endif
            csr_readdata <= '0;
        end else begin
            if (wr_ctrl) irq_en <= csr_writedata[1];
            // hardware set beats a same-cycle W1C
            if (set_done)                               done <= 1'b1;
            else if (wr_status && csr_writedata[1])     done <= 1'b0;
            if (set_ovf)                                ovf <= 1'b1;
            else if (clr_ovf || (wr_status && csr_writedata[2])) ovf <= 1'b0;
            if (wr_base) base <= csr_writedata[MEM_AW-1:0];
            if (wr_count)
                count <= (csr_writedata > 32'(MAX_COUNT)) ? 15'(MAX_COUNT) : csr_writedata[14:0];
`ifdef ACUM_WRITEBACK_EN
            if (csr_write && csr_address == CSR_DEST && !busy) dest <= csr_writedata[MEM_AW-1:0];
`endif
            if (csr_read) csr_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/acumulador_mem_master.sv
// Streams COUNT words from the data RAM and sums them signed into an ACC_W-bit accumulator.
// Define ACUM_WRITEBACK_EN to write acc[31:0] back to RAM at DEST before done.
module acumulador_mem_master #(
    parameter int ACC_W  = 40,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);
    import acumulador_pkg::*;

    state_t            state, nxt;
    logic [14:0]       idx, count;
    logic [MEM_AW-1:0] base;
`ifdef ACUM_WRITEBACK_EN
    logic [MEM_AW-1:0] dest;
`endif
    logic              vld_pipe;
    logic [ACC_W-1:0]  acc, addend, sum;
    logic              start_req, accept, busy, issue, ovf_set;

    assign busy   = state != IDLE;
    assign accept = start_req && state == IDLE;
    assign issue  = state == READ;

    assign addend  = ACC_W'(sext(mem_readdata));
    assign sum     = acc + addend;
    assign ovf_set = vld_pipe && (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start_req) nxt = (count == '0) ? DONE : READ;
            READ:  if (idx == count - 15'd1) nxt = DRAIN;
`ifdef ACUM_WRITEBACK_EN
            DRAIN: nxt = WBACK;
`else
            DRAIN: nxt = DONE;
`endif
            WBACK: nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            vld_pipe <= 1'b0;
            acc      <= '0;
        end else begin
            state <= nxt;
            if (accept)     idx <= '0;
            else if (issue) idx <= idx + 15'd1;
            // readdata arrives the cycle after the address, so valid trails issue by one
            vld_pipe <= issue;
            if (accept)        acc <= '0;
            else if (vld_pipe) acc <= sum;
        end
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        case (state)
            READ: begin
                mem_chipselect = 1'b1;
                mem_address    = base + idx[MEM_AW-1:0];
            end
`ifdef ACUM_WRITEBACK_EN
            WBACK: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dest;
                mem_writedata  = acc[31:0];
            end
`endif
            default: ;
        endcase
    end

    assign mem_debugaccess = mem_write;
    assign mem_byteenable  = 4'hF;
    assign mem_clken       = 1'b1;

    acumulador_csr #(.ACC_W(ACC_W), .MEM_AW(MEM_AW)) u_csr (
        .clk           (clk),
        .reset         (reset),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .irq           (irq),
        .busy          (busy),
        .set_done      (state == DONE),
        .set_ovf       (ovf_set),
        .clr_ovf       (accept),
        .acc           (acc),
        .start_req     (start_req),
        .base          (base),
`ifdef ACUM_WRITEBACK_EN
        .dest          (dest),
`endif
        .count         (count)
    );

endmodule

// File: tb/tb_acumulador_mem_master.sv
// Directed bench with a RAM model and address/write scoreboards.
module tb_acumulador_mem_master;

    logic        clk, reset;
    logic [2:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_writedata, csr_readdata;
    logic        irq;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [0:16383];
    logic [13:0] ram_aq;
    logic [13:0] exp_rd[$];
    logic [45:0] exp_wr[$];
    logic [13:0] dest_v;

`ifdef ACUM_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    acumulador_mem_master #(.ACC_W(40), .MEM_AW(14)) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_debugaccess(mem_debugaccess), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with registered address and unregistered q
    always @(posedge clk) if (mem_chipselect) ram_aq <= mem_address;
    assign mem_readdata = ram[ram_aq];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cs"},    32'(mem_chipselect), 0);
        check({tag, " addr"},  32'(mem_address), 0);
        check({tag, " wr"},    32'({mem_write, mem_debugaccess}), 0);
        check({tag, " wdata"}, mem_writedata, 0);
        check({tag, " be/ck"}, 32'({mem_byteenable, mem_clken}), 32'h1F);
        check({tag, " irq"},   32'(irq), 0);
        check({tag, " rdata"}, csr_readdata, 0);
    endtask

    task automatic do_run(input logic [13:0] b, input int cnt, input bit ie, input string tag);
        longint s;
        bit ov;
        int lat, k;
        logic [31:0] rd;
        logic [13:0] ad;
        logic [45:0] w;
        s = 0; ov = 0;
        for (int j = 0; j < cnt; j++) begin
            ad = b + 14'(j);
            exp_rd.push_back(ad);
            s = s + longint'($signed(ram[ad]));
            if (s > (64'sd1 <<< 39) - 1) begin ov = 1; s = s - (64'sd1 <<< 40); end
            if (s < -(64'sd1 <<< 39))    begin ov = 1; s = s + (64'sd1 <<< 40); end
        end
        if (WB == 1 && cnt > 0) exp_wr.push_back({dest_v, s[31:0]});
        lat = (cnt == 0) ? 1 : cnt + 2 + WB;
        csr_wr(3'd2, 32'(b));
        csr_wr(3'd3, 32'(cnt));
        csr_wr(3'd1, 32'h6);
        csr_wr(3'd0, {30'd0, ie, 1'b1});
        for (k = 0; k < lat + 5; k++) begin
            if (ie && irq) break;
            if (mem_chipselect && !mem_write) begin
                check({tag, " rd expected"}, 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) check({tag, " rd addr"}, 32'(mem_address), 32'(exp_rd.pop_front()));
            end
            if (mem_write) begin
                check({tag, " wr expected"}, 32'(exp_wr.size() != 0), 1);
                check({tag, " wr dbg"}, 32'(mem_debugaccess && mem_chipselect), 1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check({tag, " wr addr"}, 32'(mem_address), 32'(w[45:32]));
                    check({tag, " wr data"}, mem_writedata, w[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        if (ie) check({tag, " done latency"}, 32'(k), 32'(lat));
        else    check({tag, " irq masked"}, 32'(irq), 0);
        check({tag, " rd left"}, 32'(exp_rd.size()), 0);
        check({tag, " wr left"}, 32'(exp_wr.size()), 0);
        exp_rd.delete(); exp_wr.delete();
        csr_rd(3'd4, rd); check({tag, " lo"}, rd, s[31:0]);
        csr_rd(3'd5, rd); check({tag, " hi"}, rd, s[63:32]);
        csr_rd(3'd1, rd); check({tag, " status"}, rd, {29'd0, ov, 1'b1, 1'b0});
    endtask

    initial begin
        logic [31:0] rd;
        reset = 1'b1; csr_address = '0; csr_read = 0; csr_write = 0; csr_writedata = '0;
        dest_v = '0;
        for (int j = 0; j < 16384; j++) ram[j] = '0;
        #23;
        check_reset_outputs("reset");
        @(posedge clk); #1; reset = 1'b0;

        ram[16'h10] = 1; ram[16'h11] = 2; ram[16'h12] = 3; ram[16'h13] = 4;
        do_run(14'h10, 4, 1, "basic");

        ram[16'h20] = 32'h7FFFFFFF; ram[16'h21] = 32'h7FFFFFFF;
        do_run(14'h20, 2, 0, "maxpos");

        ram[16'h3FFE] = 32'hFFFFFFF9; ram[16'h3FFF] = 100; ram[0] = 5; ram[1] = 32'hFFFFFC18;
        do_run(14'h3FFE, 4, 1, "wrap");

        do_run(14'h0, 0, 1, "zero");

        for (int j = 0; j < 257; j++) ram[16'h1000 + j] = 32'h7FFFFFFF;
        do_run(14'h1000, 257, 1, "ovf");

        csr_wr(3'd6, 32'h100);
        csr_rd(3'd6, rd);
        check("dest reg", rd, (WB == 1) ? 32'h100 : 32'h0);
        if (WB == 1) dest_v = 14'h100;
        ram[16'h200] = 32'hFFFFFFFE; ram[16'h201] = 32'hFFFFFFFD;
        do_run(14'h200, 2, 1, "neg");

        csr_wr(3'd3, 32'hFFFF);
        csr_rd(3'd3, rd); check("count sat", rd, 32'd16384);
        csr_wr(3'd3, 32'd16385);
        csr_rd(3'd3, rd); check("count sat+1", rd, 32'd16384);

        // long run; reprogramming and restart attempts must be ignored while busy
        csr_wr(3'd2, 32'h0);
        csr_wr(3'd1, 32'h6);
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd2, 32'h55);
        csr_wr(3'd3, 32'h2);
        csr_wr(3'd0, 32'h1);
        csr_rd(3'd2, rd); check("busy base", rd, 0);
        csr_rd(3'd3, rd); check("busy count", rd, 32'd16384);
        csr_rd(3'd1, rd); check("busy status", rd, 32'h1);
        reset = 1'b1; #1;
        check_reset_outputs("abort");
        @(posedge clk); #1; reset = 1'b0; dest_v = '0;

        // reset while issuing i=2
        csr_wr(3'd2, 32'h10);
        csr_wr(3'd3, 32'd4);
        csr_wr(3'd0, 32'h3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrun addr", 32'({mem_chipselect, mem_address}), 32'h4012);
        reset = 1'b1; #1;
        check_reset_outputs("midrun");
        @(posedge clk); #1; reset = 1'b0;
        csr_rd(3'd1, rd); check("midrun status", rd, 0);
        csr_rd(3'd4, rd); check("midrun lo", rd, 0);
        do_run(14'h10, 4, 1, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
